// File: rtl/el2_ifu_ic_flush_pkg.sv
// rtl/el2_ifu_ic_flush_pkg.sv - shared types and constants for the I-cache tag flush sequencer
package el2_ifu_ic_flush_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } ic_flush_state_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int STALL_CNT_W = 16;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/el2_ifu_ic_tag_flush_ctl_if.sv
// rtl/el2_ifu_ic_tag_flush_ctl_if.sv - request/grant and tag-port bundle of the flush sequencer
interface el2_ifu_ic_tag_flush_ctl_if
  import el2_ifu_ic_flush_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int IDXW = 7
) ();

  logic                   flush_req;
  logic                   flush_busy;
  logic                   flush_done;
  logic                   fetch_rd_req;
  logic [IDXW-1:0]        fetch_rd_idx;
  logic                   fetch_rd_gnt;
  logic                   dbg_req;
  logic                   dbg_gnt;
  logic [IDXW-1:0]        tag_rw_idx;
  logic [WAYS-1:0]        tag_wr_en;
  logic [WAYS-1:0]        tag_valid_wr;
  logic                   tag_rd_en;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // master: fetch/debug side driving requests; slave: the sequencer itself
  modport master (
    output flush_req, fetch_rd_req, fetch_rd_idx, dbg_req,
    input  flush_busy, flush_done, fetch_rd_gnt, dbg_gnt,
           tag_rw_idx, tag_wr_en, tag_valid_wr, tag_rd_en, stall_cnt
  );

  modport slave (
    input  flush_req, fetch_rd_req, fetch_rd_idx, dbg_req,
    output flush_busy, flush_done, fetch_rd_gnt, dbg_gnt,
           tag_rw_idx, tag_wr_en, tag_valid_wr, tag_rd_en, stall_cnt
  );

endinterface

// File: rtl/el2_ifu_ic_flush_idx_cnt.sv
// rtl/el2_ifu_ic_flush_idx_cnt.sv - set index counter for the invalidate walk, clear beats increment
module el2_ifu_ic_flush_idx_cnt #(
  parameter int IDXW = 7
) (
  input  logic            i_clk,
  input  logic            i_rst_l,
  input  logic            i_clr,
  input  logic            i_inc,
  output logic [IDXW-1:0] o_idx,
  output logic            o_terminal
);

  logic [IDXW-1:0] r_idx;

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx      = r_idx;
  assign o_terminal = &r_idx;

endmodule

// File: rtl/el2_ifu_ic_tag_flush_ctl.sv
// rtl/el2_ifu_ic_tag_flush_ctl.sv - tag-port arbiter and valid-bit invalidate walker
// Optional stall counter enabled by `ICFLUSH_STALL_CNT_EN.
module el2_ifu_ic_tag_flush_ctl
  import el2_ifu_ic_flush_pkg::*;
#(
  parameter int ICACHE_NUM_WAYS     = 2,
  parameter int ICACHE_INDEX_HI     = 12,
  parameter int ICACHE_TAG_INDEX_LO = 6,
  parameter int FLUSH_ON_RESET      = 1
) (
  input logic                       i_clk,
  input logic                       i_rst_l,
  el2_ifu_ic_tag_flush_ctl_if.slave bus
);

  localparam int IDXW = ICACHE_INDEX_HI - ICACHE_TAG_INDEX_LO + 1;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            r_boot_pend;
  logic [IDXW-1:0] w_idx;
  logic            w_terminal;
  logic            w_idle;
  logic            w_walk;
  logic            w_done;
  logic            w_start;
  logic            w_walk_wr;
  logic            w_fetch_gnt;
  logic            w_dbg_gnt;
  logic            w_idx_clr;
  logic            w_idx_inc;

  assign w_idle = (r_state == ST_IDLE);
  assign w_walk = (r_state == ST_WALK);
  assign w_done = (r_state == ST_DONE);

  // Grants are gated by reset so every output is quiet while rst_l is low.
  assign w_dbg_gnt   = i_rst_l & bus.dbg_req;
  assign w_walk_wr   = w_walk & ~bus.dbg_req;
  assign w_fetch_gnt = i_rst_l & w_idle & bus.fetch_rd_req & ~bus.dbg_req;

  assign w_start   = bus.flush_req | (w_idle & r_boot_pend);
  assign w_idx_clr = w_start | w_done;
  assign w_idx_inc = w_walk_wr & ~w_terminal;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_WALK;
      end
      ST_WALK: begin
        if (bus.flush_req) begin
          w_state_nxt = ST_WALK;
        end else if (w_walk_wr && w_terminal) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = bus.flush_req ? ST_WALK : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Set while reset is held so the walk launches on the first clock after release.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_boot_pend <= (FLUSH_ON_RESET != 0);
    end else begin
      r_boot_pend <= 1'b0;
    end
  end

  el2_ifu_ic_flush_idx_cnt #(
    .IDXW (IDXW)
  ) u_idx_cnt (
    .i_clk      (i_clk),
    .i_rst_l    (i_rst_l),
    .i_clr      (w_idx_clr),
    .i_inc      (w_idx_inc),
    .o_idx      (w_idx),
    .o_terminal (w_terminal)
  );

  assign bus.tag_rw_idx   = w_walk_wr ? w_idx : (w_fetch_gnt ? bus.fetch_rd_idx : '0);
  assign bus.tag_wr_en    = {ICACHE_NUM_WAYS{w_walk_wr}};
  assign bus.tag_valid_wr = '0;
  assign bus.tag_rd_en    = w_fetch_gnt;
  assign bus.fetch_rd_gnt = w_fetch_gnt;
  assign bus.dbg_gnt      = w_dbg_gnt;
  assign bus.flush_busy   = w_walk;
  assign bus.flush_done   = w_done;

`ifdef ICFLUSH_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_stall_cnt <= '0;
    end else if (bus.flush_req) begin
      r_stall_cnt <= '0;
    end else if (bus.fetch_rd_req && !w_fetch_gnt && !w_idle) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_el2_ifu_ic_tag_flush_ctl.sv
// tb/tb_el2_ifu_ic_tag_flush_ctl.sv - directed and random checks of the tag flush sequencer
module tb_el2_ifu_ic_tag_flush_ctl;
  import el2_ifu_ic_flush_pkg::*;

  localparam int WAYS  = 2;
  localparam int IDXW  = 7;
  localparam int NSETS = 128;
`ifdef ICFLUSH_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_l = 1'b0;

  el2_ifu_ic_tag_flush_ctl_if #(.WAYS(WAYS), .IDXW(IDXW)) u_if  ();
  el2_ifu_ic_tag_flush_ctl_if #(.WAYS(WAYS), .IDXW(IDXW)) u_if0 ();

  el2_ifu_ic_tag_flush_ctl #(
    .ICACHE_NUM_WAYS(WAYS), .ICACHE_INDEX_HI(12), .ICACHE_TAG_INDEX_LO(6), .FLUSH_ON_RESET(1)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_l (rst_l),
    .bus     (u_if.slave)
  );

  el2_ifu_ic_tag_flush_ctl #(
    .ICACHE_NUM_WAYS(WAYS), .ICACHE_INDEX_HI(12), .ICACHE_TAG_INDEX_LO(6), .FLUSH_ON_RESET(0)
  ) u_dut0 (
    .i_clk   (clk),
    .i_rst_l (rst_l),
    .bus     (u_if0.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: mode 0 idle, 1 walking, 2 done pulse
  int m_mode  = 0;
  int m_set   = 0;
  bit m_boot  = 1'b1;
  int m_stall = 0;

  int o_busy, o_done, o_fgnt, o_dgnt, o_idx, o_wr, o_vwr, o_rd, o_stall;

  task automatic chk(input string name, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      $error("check %s", name);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_set = 0; m_boot = 1'b1; m_stall = 0;
  endtask

  task automatic cycle();
    int e_wr, e_fg, e_dg, e_idx;
    #1;
    o_busy = int'(u_if.flush_busy);  o_done = int'(u_if.flush_done);
    o_fgnt = int'(u_if.fetch_rd_gnt); o_dgnt = int'(u_if.dbg_gnt);
    o_idx  = int'(u_if.tag_rw_idx);  o_wr   = int'(u_if.tag_wr_en);
    o_vwr  = int'(u_if.tag_valid_wr); o_rd  = int'(u_if.tag_rd_en);
    o_stall = int'(u_if.stall_cnt);
    e_dg  = (rst_l && u_if.dbg_req) ? 1 : 0;
    e_wr  = (rst_l && m_mode == 1 && !u_if.dbg_req) ? 1 : 0;
    e_fg  = (rst_l && m_mode == 0 && u_if.fetch_rd_req && !u_if.dbg_req) ? 1 : 0;
    e_idx = e_wr ? m_set : (e_fg ? int'(u_if.fetch_rd_idx) : 0);
    chk("busy",     o_busy,  (m_mode == 1) ? 1 : 0);
    chk("done",     o_done,  (m_mode == 2) ? 1 : 0);
    chk("fetch_gnt", o_fgnt, e_fg);
    chk("dbg_gnt",  o_dgnt,  e_dg);
    chk("rw_idx",   o_idx,   e_idx);
    chk("wr_en",    o_wr,    e_wr ? 3 : 0);
    chk("valid_wr", o_vwr,   0);
    chk("rd_en",    o_rd,    e_fg);
    chk("stall_cnt", o_stall, m_stall);
    @(posedge clk);
    if (!rst_l) begin
      model_reset();
    end else begin
      if (u_if.flush_req) m_stall = 0;
      else if (STALL_EN && u_if.fetch_rd_req && !e_fg && m_mode != 0 && m_stall < 65535) m_stall++;
      if (u_if.flush_req || (m_mode == 0 && m_boot)) begin
        m_mode = 1; m_set = 0;
      end else if (m_mode == 1) begin
        if (e_wr) begin
          if (m_set == NSETS - 1) m_mode = 2;
          else m_set++;
        end
      end else if (m_mode == 2) begin
        m_mode = 0;
      end
      m_boot = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int wr_cnt, start_c, done_c, busy_cycles, hold, post_wr, dones, dones_pre, tail;
    bit fin, fired, this_fire;

    u_if.flush_req = 0; u_if.dbg_req = 0; u_if.fetch_rd_req = 0; u_if.fetch_rd_idx = '0;
    u_if0.flush_req = 0; u_if0.dbg_req = 0; u_if0.fetch_rd_req = 0; u_if0.fetch_rd_idx = '0;
    @(negedge clk);

    // requests active during reset must not produce any output
    u_if.dbg_req = 1; u_if.fetch_rd_req = 1; u_if.fetch_rd_idx = 7'd9; u_if.flush_req = 1;
    cycle(); cycle();
    u_if.dbg_req = 0; u_if.fetch_rd_req = 0; u_if.flush_req = 0;
    rst_l = 1'b1;

    // automatic walk after reset release
    wr_cnt = 0; start_c = -1; done_c = -1;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      cycle();
      if (o_wr != 0) begin
        if (start_c < 0) start_c = c;
        chk("boot_seq_idx", o_idx, wr_cnt);
        wr_cnt++;
      end
      if (o_done != 0) done_c = c;
    end
    chk("boot_writes", wr_cnt, NSETS);
    chk("boot_done_cycle", done_c - start_c + 1, NSETS + 1);

    // fetch read in IDLE, then refused during a walk; stall count spans WALK+DONE
    u_if.fetch_rd_req = 1; u_if.fetch_rd_idx = 7'd9;
    cycle();
    chk("idle_fetch_gnt", o_fgnt, 1);
    chk("idle_fetch_rd_en", o_rd, 1);
    chk("idle_fetch_idx", o_idx, 9);
    u_if.flush_req = 1;
    cycle();
    u_if.flush_req = 0;
    cycle();
    chk("walk_fetch_gnt", o_fgnt, 0);
    chk("walk_fetch_rd_en", o_rd, 0);
    fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      cycle();
      if (o_done != 0) fin = 1;
    end
    cycle();
    chk("stall_total", o_stall, STALL_EN ? NSETS + 1 : 0);
    u_if.fetch_rd_req = 0;

    // debug access holding the port for 5 cycles at set 40
    u_if.flush_req = 1;
    cycle();
    u_if.flush_req = 0;
    busy_cycles = 0; hold = 0; fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      u_if.dbg_req = (m_mode == 1 && m_set == 40 && hold < 5);
      if (u_if.dbg_req) hold++;
      cycle();
      if (u_if.dbg_req) begin
        chk("dbg_hold_gnt", o_dgnt, 1);
        chk("dbg_hold_nowr", o_wr, 0);
      end
      if (o_busy != 0) busy_cycles++;
      if (o_done != 0) fin = 1;
    end
    u_if.dbg_req = 0;
    chk("dbg_walk_len", busy_cycles, NSETS + 5);

    // restart of a walk at set 100
    u_if.flush_req = 1;
    cycle();
    u_if.flush_req = 0;
    fired = 0; post_wr = 0; dones = 0; dones_pre = 0; tail = 0;
    for (int c = 0; c < 400 && tail < 5; c++) begin
      u_if.flush_req = (!fired && m_mode == 1 && m_set == 100);
      this_fire = u_if.flush_req;
      cycle();
      if (fired) begin
        if (o_wr != 0) begin
          if (post_wr == 0) chk("abort_restart_idx", o_idx, 0);
          post_wr++;
        end
        if (o_done != 0) dones++;
        if (dones > 0) tail++;
      end else if (o_done != 0) begin
        dones_pre++;
      end
      if (this_fire) fired = 1;
    end
    u_if.flush_req = 0;
    chk("abort_writes", post_wr, NSETS);
    chk("abort_dones", dones, 1);
    chk("abort_early_done", dones_pre, 0);

    // asynchronous reset in the middle of a walk
    u_if.flush_req = 1;
    cycle();
    u_if.flush_req = 0;
    for (int c = 0; c < 200 && !(m_mode == 1 && m_set == 64); c++) cycle();
    #1;
    chk("pre_rst_idx", int'(u_if.tag_rw_idx), 64);
    #1;
    rst_l = 1'b0;
    #1;
    chk("async_rst_busy", int'(u_if.flush_busy), 0);
    chk("async_rst_wr_en", int'(u_if.tag_wr_en), 0);
    chk("async_rst_idx", int'(u_if.tag_rw_idx), 0);
    model_reset();
    cycle();
    rst_l = 1'b1;
    cycle();
    cycle();
    chk("reboot_busy", int'(u_if.flush_busy), 1);
    chk("no_boot_idle", int'(u_if0.flush_busy), 0);
    u_if0.flush_req = 1;
    cycle();
    u_if0.flush_req = 0;
    chk("dut0_start_busy", int'(u_if0.flush_busy), 1);
    chk("dut0_first_idx", int'(u_if0.tag_rw_idx), 0);
    chk("dut0_first_wr_en", int'(u_if0.tag_wr_en), 3);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      u_if.flush_req    = ($urandom % 400) == 0;
      u_if.dbg_req      = ($urandom % 4) == 0;
      u_if.fetch_rd_req = ($urandom % 2) == 0;
      u_if.fetch_rd_idx = 7'($urandom);
      cycle();
    end
    u_if.flush_req = 0; u_if.dbg_req = 0; u_if.fetch_rd_req = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
